adder_err_sweep: RTL and testbench

ADDER_ERR_SWEEP -- requirements
Module: adder_err_sweep

---
 rtl/adder_err_pkg.sv | 17 +
 rtl/adder_err_sweep_exact.sv | 12 +
 rtl/adder_err_sweep.sv | 183 ++++++++++++++++++
 tb/tb_adder_err_sweep.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_err_pkg.sv
// Shared types and derived widths for the adder error sweep block.
package adder_err_pkg;

  localparam int N_DEF   = 4;
  localparam int VEC_W   = 2 * N_DEF;
  localparam int SUM_W   = N_DEF + 1;
  localparam int CNT_W   = 2 * N_DEF + 1;
  localparam int ACC_W   = 3 * N_DEF + 1;
  localparam int NUM_VEC = 1 << VEC_W;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/adder_err_sweep_exact.sv
// Golden reference adder: exact N+1-bit sum of two N-bit operands.
module adder_exact #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_err_sweep.sv
// Exhaustive error sweep of an external N-bit adder against an exact reference.
// Optional macro ADDER_ERR_FIRST_EN adds capture of the first mismatching vector.
module adder_err_sweep
  import adder_err_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   dut_a,
  output logic [N-1:0]   dut_b,
  input  logic [N:0]     dut_sum,
  output logic [2*N:0]   err_count,
  output logic [N:0]     max_err,
  output logic [3*N:0]   sum_abs_err
`ifdef ADDER_ERR_FIRST_EN
  ,
  output logic           first_err_vld,
  output logic [2*N-1:0] first_err_vec
`endif
);

  localparam int VW = 2 * N;
  localparam int SW = N + 1;
  localparam int CW = 2 * N + 1;
  localparam int AW = 3 * N + 1;

  state_t          state_q, state_d;
  logic [VW-1:0]   v_q, v_d;
  logic            drain_q, drain_d;
  // [0]: vector on dut_a/dut_b is live, [1]: stage-1 holds a live sample
  logic [1:0]      vld_pipe_q, vld_pipe_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [SW-1:0]   s1_sum_q, s1_sum_d, s1_exact_q, s1_exact_d;
  logic [CW-1:0]   err_q, err_d;
  logic [SW-1:0]   max_q, max_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   exact_sum;
  logic [SW-1:0]   abs_diff;
  logic            accept;
  logic            last_vec;
`ifdef ADDER_ERR_FIRST_EN
  logic [VW-1:0]   s1_vec_q, s1_vec_d;
  logic            first_vld_q, first_vld_d;
  logic [VW-1:0]   first_vec_q, first_vec_d;
`endif

  adder_exact #(.N(N)) u_exact (
    .a   (a_q),
    .b   (b_q),
    .sum (exact_sum)
  );

  always_comb begin
    abs_diff = (s1_sum_q >= s1_exact_q) ? (s1_sum_q - s1_exact_q)
                                        : (s1_exact_q - s1_sum_q);
  end

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_vec = vld_pipe_q[0] && ({b_q, a_q} == {VW{1'b1}});

  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    drain_d       = drain_q;
    a_d           = '0;
    b_d           = '0;
    vld_pipe_d    = {vld_pipe_q[0], 1'b0};
    s1_sum_d      = dut_sum;
    s1_exact_d    = exact_sum;
    err_d         = err_q;
    max_d         = max_q;
    acc_d         = acc_q;
`ifdef ADDER_ERR_FIRST_EN
    s1_vec_d      = {b_q, a_q};
    first_vld_d   = first_vld_q;
    first_vec_d   = first_vec_q;
`endif

    if (vld_pipe_q[1]) begin
      if (abs_diff != '0) err_d = err_q + CW'(1);
      if (abs_diff > max_q) max_d = abs_diff;
      acc_d = acc_q + AW'(abs_diff);
`ifdef ADDER_ERR_FIRST_EN
      if ((abs_diff != '0) && !first_vld_q) begin
        first_vld_d = 1'b1;
        first_vec_d = s1_vec_q;
      end
`endif
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d    = ST_SWEEP;
          v_d        = '0;
          vld_pipe_d = '0;
          err_d      = '0;
          max_d      = '0;
          acc_d      = '0;
`ifdef ADDER_ERR_FIRST_EN
          first_vld_d = 1'b0;
          first_vec_d = '0;
`endif
        end
      end
      ST_SWEEP: begin
        a_d           = v_q[N-1:0];
        b_d           = v_q[VW-1:N];
        v_d           = v_q + VW'(1);
        vld_pipe_d[0] = 1'b1;
        // Last vector is being sampled this edge; stop presenting so the
        // wrapped index 0 never reaches the comparator.
        if (last_vec) begin
          state_d       = ST_DRAIN;
          a_d           = '0;
          b_d           = '0;
          vld_pipe_d[0] = 1'b0;
          drain_d       = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q) state_d = ST_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      v_q        <= '0;
      drain_q    <= 1'b0;
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s1_sum_q   <= '0;
      s1_exact_q <= '0;
      err_q      <= '0;
      max_q      <= '0;
      acc_q      <= '0;
`ifdef ADDER_ERR_FIRST_EN
      s1_vec_q    <= '0;
      first_vld_q <= 1'b0;
      first_vec_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_sum_q   <= s1_sum_d;
      s1_exact_q <= s1_exact_d;
      err_q      <= err_d;
      max_q      <= max_d;
      acc_q      <= acc_d;
`ifdef ADDER_ERR_FIRST_EN
      s1_vec_q    <= s1_vec_d;
      first_vld_q <= first_vld_d;
      first_vec_q <= first_vec_d;
`endif
    end
  end

  assign busy        = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign dut_a       = a_q;
  assign dut_b       = b_q;
  assign err_count   = err_q;
  assign max_err     = max_q;
  assign sum_abs_err = acc_q;
`ifdef ADDER_ERR_FIRST_EN
  assign first_err_vld = first_vld_q;
  assign first_err_vec = first_vec_q;
`endif

endmodule

// File: tb/tb_adder_err_sweep.sv
// Bench for adder_err_sweep: several adders-under-test against a plain metric model.
module tb_adder_err_sweep;
  import adder_err_pkg::*;

  localparam int N = N_DEF;

  logic               clk = 1'b0;
  logic               rst, start;
  logic               busy, done;
  logic [N-1:0]       dut_a, dut_b;
  logic [SUM_W-1:0]   dut_sum;
  logic [CNT_W-1:0]   err_count;
  logic [SUM_W-1:0]   max_err;
  logic [ACC_W-1:0]   sum_abs_err;
`ifdef ADDER_ERR_FIRST_EN
  logic               first_err_vld;
  logic [VEC_W-1:0]   first_err_vec;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int mode        = 0;
  int rnd_tab [NUM_VEC];
  bit rnd_hit [NUM_VEC];

  always #5 clk = ~clk;

  adder_err_sweep #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .dut_a       (dut_a),
    .dut_b       (dut_b),
    .dut_sum     (dut_sum),
    .err_count   (err_count),
    .max_err     (max_err),
    .sum_abs_err (sum_abs_err)
`ifdef ADDER_ERR_FIRST_EN
    ,
    .first_err_vld (first_err_vld),
    .first_err_vec (first_err_vec)
`endif
  );

  // Adder under test: 0 exact, 1 stuck at zero, 2 carry-out dropped, 3 random faults
  function automatic int aut(input int m, input int a, input int b);
    case (m)
      0:       return a + b;
      1:       return 0;
      2:       return (a + b) % (1 << N);
      default: return rnd_hit[b * (1 << N) + a] ? rnd_tab[b * (1 << N) + a] : a + b;
    endcase
  endfunction

  always_comb dut_sum = SUM_W'(aut(mode, int'(dut_a), int'(dut_b)));

  // Metrics over the first `limit` vectors in sweep order (index = b*2^N + a)
  task automatic model(input int limit, output int e_cnt, output int e_max,
                       output int e_sum, output int e_first);
    e_cnt = 0; e_max = 0; e_sum = 0; e_first = -1;
    for (int v = 0; v < limit; v++) begin
      int a, b, d;
      a = v % (1 << N);
      b = v / (1 << N);
      d = aut(mode, a, b) - (a + b);
      if (d < 0) d = -d;
      if (d != 0) begin
        e_cnt++;
        if (e_first < 0) e_first = v;
      end
      if (d > e_max) e_max = d;
      e_sum += d;
    end
  endtask

  // Stimulus only: start, then follow the sweep; returns latency and protocol slips
  task automatic sweep(output int lat, output int bad, input int s1, input int s2);
    int exp_v;
    lat = 0; bad = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (done !== 1'b0 || busy !== 1'b1 || err_count !== '0 || sum_abs_err !== '0) bad++;
    while (done !== 1'b1 && lat < 1000) begin
      if (lat == s1 || lat == s2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
      exp_v = (lat >= 1 && lat <= NUM_VEC) ? lat - 1 : 0;
      if ({dut_b, dut_a} !== VEC_W'(exp_v)) bad++;
      if (done !== 1'b1 && busy !== 1'b1) bad++;
      if (done === 1'b1 && busy !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, dut_a, dut_b} !== '0 || err_count !== '0 || max_err !== '0 || sum_abs_err !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%0b done=%0b a=%0d b=%0d err=%0d max=%0d sum=%0d, want all 0",
               busy, done, dut_a, dut_b, err_count, max_err, sum_abs_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exact;
    int lat, bad;
    mode = 0;
    sweep(lat, bad, -1, -1);
    vectors++;
    if (lat != NUM_VEC + 3 || bad != 0) begin
      miscompares++;
      $display("FAIL exact_timing: latency %0d slips %0d, want %0d and 0", lat, bad, NUM_VEC + 3);
    end
    vectors++;
    if (err_count !== '0 || max_err !== '0 || sum_abs_err !== '0) begin
      miscompares++;
      $display("FAIL exact_metrics: err=%0d max=%0d sum=%0d, want 0 0 0", err_count, max_err, sum_abs_err);
    end
  endtask

  task automatic test_zero;
    int lat, bad;
    mode = 1;
    sweep(lat, bad, -1, -1);
    vectors++;
    if (lat != NUM_VEC + 3 || bad != 0 || err_count !== 255 || max_err !== 30 || sum_abs_err !== 3840) begin
      miscompares++;
      $display("FAIL zero_adder: lat=%0d slips=%0d err=%0d max=%0d sum=%0d, want 259 0 255 30 3840",
               lat, bad, err_count, max_err, sum_abs_err);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (err_count !== 255 || max_err !== 30 || sum_abs_err !== 3840 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_hold: err=%0d max=%0d sum=%0d done=%0b, want 255 30 3840 1",
               err_count, max_err, sum_abs_err, done);
    end
  endtask

  task automatic test_carry;
    int lat, bad;
    mode = 2;
    sweep(lat, bad, -1, -1);
    vectors++;
    if (bad != 0 || err_count !== 120 || max_err !== 16 || sum_abs_err !== 1920) begin
      miscompares++;
      $display("FAIL carry_drop: slips=%0d err=%0d max=%0d sum=%0d, want 0 120 16 1920",
               bad, err_count, max_err, sum_abs_err);
    end
`ifdef ADDER_ERR_FIRST_EN
    vectors++;
    if (first_err_vld !== 1'b1 || first_err_vec !== 8'h1F) begin
      miscompares++;
      $display("FAIL carry_first: vld=%0b vec=%0h, want 1 1f", first_err_vld, first_err_vec);
    end
`endif
  endtask

  task automatic test_random;
    int lat, bad, e_cnt, e_max, e_sum, e_first;
    mode = 3;
    for (int it = 0; it < 3; it++) begin
      for (int v = 0; v < NUM_VEC; v++) begin
        rnd_hit[v] = ($urandom_range(3) == 0);
        rnd_tab[v] = int'($urandom_range((1 << SUM_W) - 1));
      end
      model(NUM_VEC, e_cnt, e_max, e_sum, e_first);
      sweep(lat, bad, -1, -1);
      vectors++;
      if (lat != NUM_VEC + 3 || bad != 0 || err_count !== CNT_W'(e_cnt) ||
          max_err !== SUM_W'(e_max) || sum_abs_err !== ACC_W'(e_sum)) begin
        miscompares++;
        $display("FAIL random_%0d: lat=%0d slips=%0d err=%0d max=%0d sum=%0d, want 259 0 %0d %0d %0d",
                 it, lat, bad, err_count, max_err, sum_abs_err, e_cnt, e_max, e_sum);
      end
`ifdef ADDER_ERR_FIRST_EN
      vectors++;
      if (first_err_vld !== (e_first >= 0) || (e_first >= 0 && first_err_vec !== VEC_W'(e_first))) begin
        miscompares++;
        $display("FAIL random_first_%0d: vld=%0b vec=%0h, want first index %0d",
                 it, first_err_vld, first_err_vec, e_first);
      end
`endif
    end
  endtask

  task automatic test_rst_mid;
    int lat, bad, e_cnt, e_max, e_sum, e_first;
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    model(98, e_cnt, e_max, e_sum, e_first);
    vectors++;
    if (busy !== 1'b1 || err_count !== CNT_W'(e_cnt) || max_err !== SUM_W'(e_max) ||
        sum_abs_err !== ACC_W'(e_sum)) begin
      miscompares++;
      $display("FAIL partial_at_100: busy=%0b err=%0d max=%0d sum=%0d, want 1 %0d %0d %0d",
               busy, err_count, max_err, sum_abs_err, e_cnt, e_max, e_sum);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    vectors++;
    if ({busy, done, dut_a, dut_b} !== '0 || err_count !== '0 || max_err !== '0 || sum_abs_err !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: busy=%0b done=%0b a=%0d b=%0d err=%0d max=%0d sum=%0d, want all 0",
               busy, done, dut_a, dut_b, err_count, max_err, sum_abs_err);
    end
    mode = 0;
    sweep(lat, bad, -1, -1);
    vectors++;
    if (lat != NUM_VEC + 3 || bad != 0 || err_count !== '0 || max_err !== '0 || sum_abs_err !== '0) begin
      miscompares++;
      $display("FAIL rst_then_exact: lat=%0d slips=%0d err=%0d max=%0d sum=%0d, want 259 0 0 0 0",
               lat, bad, err_count, max_err, sum_abs_err);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bad, e_cnt, e_max, e_sum, e_first;
    mode = 3;
    model(NUM_VEC, e_cnt, e_max, e_sum, e_first);
    sweep(lat, bad, 49, 257);
    vectors++;
    if (lat != NUM_VEC + 3 || bad != 0 || err_count !== CNT_W'(e_cnt) ||
        max_err !== SUM_W'(e_max) || sum_abs_err !== ACC_W'(e_sum)) begin
      miscompares++;
      $display("FAIL start_ignored: lat=%0d slips=%0d err=%0d max=%0d sum=%0d, want 259 0 %0d %0d %0d",
               lat, bad, err_count, max_err, sum_abs_err, e_cnt, e_max, e_sum);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_hold: done=%0b busy=%0b, want 1 0", done, busy);
    end
    sweep(lat, bad, -1, -1);
    vectors++;
    if (lat != NUM_VEC + 3 || bad != 0 || err_count !== CNT_W'(e_cnt) ||
        max_err !== SUM_W'(e_max) || sum_abs_err !== ACC_W'(e_sum)) begin
      miscompares++;
      $display("FAIL restart_from_done: lat=%0d slips=%0d err=%0d max=%0d sum=%0d, want 259 0 %0d %0d %0d",
               lat, bad, err_count, max_err, sum_abs_err, e_cnt, e_max, e_sum);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_zero();
    test_carry();
    test_random();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
